// File: rtl/operand_fetch_if.sv
// Operand-fetch bundle: request, operand return, writeback and register-bank
// drive. The slave modport is the fetch unit; master is its environment.
interface operand_fetch_if;
  logic        reqValid;
  logic        reqReady;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic        opValid;
  logic        opReady;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        wbValid;
  logic        wbReady;
  logic [3:0]  wbReg;
  logic [31:0] wbData;
  logic [3:0]  bankRegNum;
  logic        bankWriteEnable;
  logic [31:0] bankDataOut;
  logic [31:0] bankDataIn;

  modport slave (
    input  reqValid, rs1, rs2, opReady, wbValid, wbReg, wbData, bankDataIn,
    output reqReady, opValid, op1, op2, wbReady, bankRegNum, bankWriteEnable, bankDataOut
  );

  modport master (
    output reqValid, rs1, rs2, opReady, wbValid, wbReg, wbData, bankDataIn,
    input  reqReady, opValid, op1, op2, wbReady, bankRegNum, bankWriteEnable, bankDataOut
  );
endinterface

// File: rtl/operand_fetch.sv
// Two-operand fetch from a single-port register bank, with writeback merged
// into the idle slot (writeback wins over a same-cycle read request).
// Optional macro OPERAND_FETCH_X0_HARDWIRE_EN: register 0 reads as zero and
// writebacks to it are accepted but never reach the bank.
//
// state  | meaning
// IDLE   | accept writeback (priority) or a read request
// READ_A | bank addressed with rs1, op1 captured at the edge
// READ_B | bank addressed with rs2, op2 captured at the edge
// DONE   | operands presented until the consumer takes them
module operand_fetch (
  input logic           clk,
  input logic           reset,
  operand_fetch_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ_A, READ_B, DONE} state_t;

  state_t      state;
  logic [3:0]  rs1_q;
  logic [3:0]  rs2_q;
  logic [31:0] op1_q;
  logic [31:0] op2_q;
  logic        op_valid_q;
  logic [31:0] rd_data;
  logic        wb_sel;

  // Bank read data as seen by the operand registers.
`ifdef OPERAND_FETCH_X0_HARDWIRE_EN
  assign rd_data = (bus.bankRegNum == 4'd0) ? 32'd0 : bus.bankDataIn;
`else
  assign rd_data = bus.bankDataIn;
`endif

  // Writeback only happens out of reset in IDLE.
  assign wb_sel = !reset && (state == IDLE) && bus.wbValid;

  // Sequencer and operand registers; reset overrides every input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rs1_q      <= 4'd0;
      rs2_q      <= 4'd0;
      op1_q      <= 32'd0;
      op2_q      <= 32'd0;
      op_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.reqValid && !bus.wbValid) begin
            rs1_q <= bus.rs1;
            rs2_q <= bus.rs2;
            state <= READ_A;
          end
        end
        READ_A: begin
          op1_q <= rd_data;
          state <= READ_B;
        end
        READ_B: begin
          op2_q      <= rd_data;
          op_valid_q <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (bus.opReady) begin
            op_valid_q <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake readies and bank drive; everything parks at zero in reset.
  always_comb begin
    bus.reqReady        = 1'b0;
    bus.wbReady         = 1'b0;
    bus.bankRegNum      = 4'd0;
    bus.bankWriteEnable = 1'b0;
    bus.bankDataOut     = 32'd0;
    if (!reset) begin
      case (state)
        IDLE: begin
          bus.wbReady  = 1'b1;
          bus.reqReady = !bus.wbValid;
          if (wb_sel) begin
            bus.bankRegNum  = bus.wbReg;
            bus.bankDataOut = bus.wbData;
`ifdef OPERAND_FETCH_X0_HARDWIRE_EN
            bus.bankWriteEnable = (bus.wbReg != 4'd0);
`else
            bus.bankWriteEnable = 1'b1;
`endif
          end
        end
        READ_A:  bus.bankRegNum = rs1_q;
        READ_B:  bus.bankRegNum = rs2_q;
        default: bus.bankRegNum = 4'd0;
      endcase
    end
  end

  assign bus.op1     = op1_q;
  assign bus.op2     = op2_q;
  assign bus.opValid = op_valid_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural register bank and an
// operand scoreboard drained by an independent monitor.
module tb_operand_fetch;

`ifdef OPERAND_FETCH_X0_HARDWIRE_EN
  localparam logic X0 = 1'b1;
`else
  localparam logic X0 = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  operand_fetch_if ifc ();

  operand_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  // Register bank model: combinational read, write on rising edge.
  logic [31:0] bank [16];
  assign ifc.bankDataIn = bank[ifc.bankRegNum];
  always @(posedge clk) if (ifc.bankWriteEnable) bank[ifc.bankRegNum] <= ifc.bankDataOut;

  int errors = 0;
  int checks = 0;
  int wr_count = 0;
  logic [63:0] sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every operand handoff must match the oldest expected pair.
  always @(negedge clk) begin
    if (ifc.bankWriteEnable) wr_count++;
    if (!reset && ifc.opValid && ifc.opReady) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_op: got op1=%h op2=%h expected none", ifc.op1, ifc.op2);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("op1", ifc.op1, e[63:32]);
        chk("op2", ifc.op2, e[31:0]);
      end
    end
  end

  task automatic do_wb(input logic [3:0] r, input logic [31:0] d, input logic exp_we);
    logic got;
    ifc.wbValid = 1'b1; ifc.wbReg = r; ifc.wbData = d;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifc.wbReady) begin got = 1'b1; break; end
    end
    chk("wb_accept", {31'd0, got}, 32'd1);
    chk("wb_we", {31'd0, ifc.bankWriteEnable}, {31'd0, exp_we});
    @(posedge clk); #1;
    ifc.wbValid = 1'b0;
  endtask

  task automatic do_req(input logic [3:0] a, input logic [3:0] b,
                        input logic [31:0] e1, input logic [31:0] e2);
    logic got;
    ifc.reqValid = 1'b1; ifc.rs1 = a; ifc.rs2 = b;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifc.reqReady) begin got = 1'b1; break; end
    end
    chk("req_accept", {31'd0, got}, 32'd1);
    if (got) sb.push_back({e1, e2});
    @(posedge clk); #1;
    ifc.reqValid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    chk("sb_drain", sb.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int wr0;
    for (int i = 0; i < 16; i++) bank[i] = 32'hA000_0000 | i;
    reset = 1'b1;
    ifc.reqValid = 1'b1; ifc.rs1 = 4'd1; ifc.rs2 = 4'd2;
    ifc.opReady = 1'b1;
    ifc.wbValid = 1'b1; ifc.wbReg = 4'd2; ifc.wbData = 32'h5555_5555;

    // Reset: outputs parked, no write even with wbValid high.
    @(negedge clk); @(negedge clk);
    chk("rst_reqReady", {31'd0, ifc.reqReady}, 32'd0);
    chk("rst_wbReady", {31'd0, ifc.wbReady}, 32'd0);
    chk("rst_we", {31'd0, ifc.bankWriteEnable}, 32'd0);
    chk("rst_opValid", {31'd0, ifc.opValid}, 32'd0);
    chk("rst_op1", ifc.op1, 32'd0);
    chk("rst_op2", ifc.op2, 32'd0);
    chk("rst_regnum", {28'd0, ifc.bankRegNum}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; ifc.reqValid = 1'b0; ifc.wbValid = 1'b0;
    @(negedge clk);
    chk("rst_bank2", bank[2], 32'hA000_0002);
    chk("idle_reqReady", {31'd0, ifc.reqReady}, 32'd1);
    chk("idle_regnum", {28'd0, ifc.bankRegNum}, 32'd0);
    @(posedge clk); #1;

    // Writeback then read back; reg0 is hardwired only with the macro.
    do_wb(4'd3, 32'hDEAD_BEEF, 1'b1);
    do_req(4'd3, 4'd0, 32'hDEAD_BEEF, X0 ? 32'd0 : 32'hA000_0000);
    drain();

    // Latency: rs1 on the bank after edge N, rs2 after N+1, opValid after N+2.
    ifc.reqValid = 1'b1; ifc.rs1 = 4'd5; ifc.rs2 = 4'd9;
    @(negedge clk);
    chk("lat_reqReady", {31'd0, ifc.reqReady}, 32'd1);
    sb.push_back({32'hA000_0005, 32'hA000_0009});
    @(posedge clk); #1;
    ifc.reqValid = 1'b0;
    @(negedge clk);
    chk("lat_regnum_a", {28'd0, ifc.bankRegNum}, 32'd5);
    chk("lat_busy_ready", {30'd0, ifc.reqReady, ifc.wbReady}, 32'd0);
    chk("lat_opValid_a", {31'd0, ifc.opValid}, 32'd0);
    @(negedge clk);
    chk("lat_regnum_b", {28'd0, ifc.bankRegNum}, 32'd9);
    chk("lat_we_b", {31'd0, ifc.bankWriteEnable}, 32'd0);
    @(negedge clk);
    chk("lat_opValid", {31'd0, ifc.opValid}, 32'd1);
    drain();

    // Same-cycle writeback and request: write first, then read sees it.
    ifc.wbValid = 1'b1; ifc.wbReg = 4'd7; ifc.wbData = 32'hCAFE_F00D;
    ifc.reqValid = 1'b1; ifc.rs1 = 4'd7; ifc.rs2 = 4'd7;
    @(negedge clk);
    chk("pri_reqReady", {31'd0, ifc.reqReady}, 32'd0);
    chk("pri_we", {31'd0, ifc.bankWriteEnable}, 32'd1);
    chk("pri_regnum", {28'd0, ifc.bankRegNum}, 32'd7);
    @(posedge clk); #1;
    ifc.wbValid = 1'b0;
    @(negedge clk);
    chk("pri_reqReady2", {31'd0, ifc.reqReady}, 32'd1);
    sb.push_back({32'hCAFE_F00D, 32'hCAFE_F00D});
    @(posedge clk); #1;
    ifc.reqValid = 1'b0;
    drain();

    // Stall in DONE: operands hold, writeback blocked until release.
    ifc.opReady = 1'b0;
    do_req(4'd3, 4'd7, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    for (int i = 0; i < 20 && !ifc.opValid; i++) @(negedge clk);
    chk("stall_opValid_up", {31'd0, ifc.opValid}, 32'd1);
    ifc.wbValid = 1'b1; ifc.wbReg = 4'd4; ifc.wbData = 32'h1111_2222;
    wr0 = wr_count;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_opValid", {31'd0, ifc.opValid}, 32'd1);
      chk("stall_op1", ifc.op1, 32'hDEAD_BEEF);
      chk("stall_op2", ifc.op2, 32'hCAFE_F00D);
      chk("stall_wbReady", {31'd0, ifc.wbReady}, 32'd0);
    end
    chk("stall_no_write", wr_count - wr0, 32'd0);
    chk("stall_bank4", bank[4], 32'hA000_0004);
    @(posedge clk); #1;
    ifc.opReady = 1'b1;
    do_wb(4'd4, 32'h1111_2222, 1'b1);
    do_req(4'd4, 4'd4, 32'h1111_2222, 32'h1111_2222);
    drain();

    // Reset in READ_B abandons the fetch and suppresses a pending write.
    ifc.reqValid = 1'b1; ifc.rs1 = 4'd1; ifc.rs2 = 4'd2;
    @(negedge clk);
    chk("abort_accept", {31'd0, ifc.reqReady}, 32'd1);
    @(posedge clk); #1;
    ifc.reqValid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; ifc.wbValid = 1'b1; ifc.wbReg = 4'd5; ifc.wbData = 32'hFFFF_FFFF;
    wr0 = wr_count;
    @(negedge clk);
    chk("abort_we", {31'd0, ifc.bankWriteEnable}, 32'd0);
    chk("abort_wbReady", {31'd0, ifc.wbReady}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; ifc.wbValid = 1'b0;
    @(negedge clk);
    chk("abort_opValid", {31'd0, ifc.opValid}, 32'd0);
    chk("abort_op1", ifc.op1, 32'd0);
    chk("abort_op2", ifc.op2, 32'd0);
    chk("abort_idle", {31'd0, ifc.reqReady}, 32'd1);
    chk("abort_no_write", wr_count - wr0, 32'd0);
    chk("abort_bank5", bank[5], 32'hA000_0005);
    @(posedge clk); #1;

    // Register 0 writeback and readback.
    do_wb(4'd0, 32'h1234_5678, !X0);
    do_req(4'd0, 4'd3, X0 ? 32'd0 : 32'h1234_5678, 32'hDEAD_BEEF);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; ports listed as name, direction, width, meaning.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 reqValid  in  1  operand-read request valid.
REQ-005 reqReady  out  1  request accepted when reqValid and reqReady are both high at a clk edge.
REQ-006 rs1, rs2  in  4 each  source register numbers, sampled on request acceptance.
REQ-007 opValid  out  1  op1/op2 hold valid operands.
REQ-008 opReady  in  1  consumer takes operands when opValid and opReady are both high.
REQ-009 op1, op2  out  32 each  registered operand values.
REQ-010 wbValid  in  1  writeback request valid.
REQ-011 wbReady  out  1  writeback accepted when wbValid and wbReady are both high.
REQ-012 wbReg  in  4, wbData  in  32  writeback destination and value.
REQ-013 bankRegNum  out  4, bankWriteEnable  out  1, bankDataOut  out  32  drive the register bank's regNum, writeEnable and dataIn.
REQ-014 bankDataIn  in  32  register bank's combinational read data for bankRegNum.

Function
REQ-015 SHALL implement the FSM states IDLE, READ_A, READ_B and DONE.
REQ-016 IDLE: wbReady=1; reqReady=!wbValid, so writeback has priority over a read request in the same cycle.
REQ-017 IDLE with wbValid=1: same cycle, bankRegNum=wbReg, bankDataOut=wbData, bankWriteEnable=1; state stays IDLE.
REQ-018 IDLE with reqValid=1 and wbValid=0: latch rs1/rs2, go to READ_A.
REQ-019 READ_A: bankRegNum=latched rs1, bankWriteEnable=0; op1<=bankDataIn at edge; go to READ_B.
REQ-020 READ_B: bankRegNum=latched rs2, bankWriteEnable=0; op2<=bankDataIn at edge; go to DONE.
REQ-021 DONE: opValid=1, op1/op2 held stable; on opReady=1 go to IDLE; otherwise hold indefinitely.
REQ-022 Latency: request accepted at edge N -> opValid high in the cycle after edge N+2; one request in flight at most.
REQ-023 reqReady=0 and wbReady=0 in READ_A, READ_B and DONE; writebacks stall during a fetch.
REQ-024 Writeback is committed before the next read, so an immediately following read of the same register returns the new value.
REQ-025 Idle bank drive (no write): bankRegNum=0, bankWriteEnable=0, bankDataOut=0.
REQ-026 rs1==rs2 is legal; both reads are still performed and both operands are equal.
REQ-027 bankWriteEnable is asserted only in IDLE and never in any other state.

Reset
REQ-028 reset SHALL have priority over all inputs: state=IDLE, opValid=0, op1=op2=0, latched rs1/rs2=0.
REQ-029 Reset mid-fetch SHALL abandon the request without a bank write; a reset cycle with wbValid=1 SHALL NOT write.
REQ-030 During reset, combinational outputs SHALL follow the IDLE rules with writes suppressed: reqReady=0, wbReady=0, bankWriteEnable=0.

Configuration
REQ-031 Macro OPERAND_FETCH_X0_HARDWIRE_EN SHALL select register-0 behaviour.
REQ-032 Defined: writeback to wbReg=0 is accepted (wbReady=1) with bankWriteEnable=0, and reads of register 0 load 0 regardless of bankDataIn.
REQ-033 Undefined: register 0 is written and read like any other register.

Verification
REQ-034 Bench: wb reg3=0xDEADBEEF, then req rs1=3 rs2=0 -> op1=0xDEADBEEF; op2=0 with macro, otherwise bank content.
REQ-035 Bench: wbValid and reqValid in the same IDLE cycle -> write happens first; request accepted next cycle; data reflects the write.
REQ-036 Bench: request at edge N -> bankRegNum=rs1 in cycle N+1, =rs2 in N+2, opValid=1 in N+3.
REQ-037 Bench: opReady held 0 for 5 cycles in DONE -> opValid, op1, op2 stable; wbReady=0; wb performed only after release.
REQ-038 Bench: reset asserted in READ_B -> next cycle IDLE, opValid=0, op1=op2=0, no bankWriteEnable pulse.
REQ-039 Bench: wb to reg0=0x12345678 with macro defined -> bankWriteEnable stays 0; a later read of reg0 gives 0.
